cursor_sprite_loader: RTL and testbench
=======================================

# cursor_sprite_loader

Write-side companion to the cursor sprite source: fills the 32x32, 1-bit-per-pixel cursor sprite RAM through its write port (we / addr_w / pixel_in). Accepts one 32-bit bitmap row per valid/ready handshake, serialises it into 32 single-pixel RAM writes, and also offers a zero-fill (clear) sequence. Sits between the processor/MMIO side and the cursor sprite RAM in the video path.

## Interface
- ADDR, 10, sprite RAM address width; fixed as {row[4:0], col[4:0]}
- ROW_W, 32, bits per bitmap row; equals sprite width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin loading a new 32-row sprite
- clear  in  1  pulse: zero-fill all 1024 RAM locations
- row_data  in  32  bitmap row; row_data[31-c] is column c (MSB = leftmost)
- row_valid  in  1  row_data valid
- row_ready  out  1  loader can accept a row this cycle
- we  out  1  sprite RAM write enable
- addr_w  out  10  sprite RAM write address {row, col}
- pixel_out  out  1  sprite RAM write data (palette code)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a load or clear completes

## Operation
- States: IDLE, CLEAR, WAIT_ROW, SHIFT.
- IDLE: on clear=1 -> CLEAR (row/col counters = 0). Else on start=1 -> WAIT_ROW (row = 0). Clear wins if both asserted together.
- CLEAR: each cycle we=1, pixel_out=0, addr_w = counter; counter 0..1023. After address 1023 -> IDLE, done=1 in the following cycle.
- WAIT_ROW: row_ready=1. On row_valid && row_ready, latch row_data into 32-bit shift register, col = 0 -> SHIFT.
- SHIFT: each cycle we=1, addr_w={row,col}, pixel_out = shift register MSB; shift left by 1, col += 1. After col 31: if row = 31 -> IDLE with done pulse; else row += 1 -> WAIT_ROW.
- start/clear while busy: ignored; no abort path.
- row_valid outside WAIT_ROW: ignored, data not consumed (row_ready=0).
- Counters are 5-bit; wrap from 31 never observed because the FSM leaves SHIFT/CLEAR first.
- All outputs registered (driven from flops); no combinational path from inputs to outputs.

## Timing
- Reset values: we=0, addr_w=0, pixel_out=0, row_ready=0, busy=0, done=0, state IDLE. Reset mid-operation terminates immediately (async); partial sprite remains in RAM, no done pulse.
- start sampled at edge T -> busy=1 and row_ready=1 from T+1.
- Row handshake at edge T -> row_ready=0 from T+1; writes to col 0..31 occupy cycles T+1..T+32 (we high exactly 32 cycles); row_ready=1 again at T+33. Max throughput 1 row / 33 cycles; full sprite minimum 32*33 cycles after first handshake.
- Last write (row 31, col 31) in cycle N -> we=0, busy=0, done=1 in cycle N+1; done low at N+2.
- clear sampled at T -> writes addresses 0..1023 in cycles T+1..T+1024, done=1 at T+1025.
- Sprite RAM is written one cycle after each we/addr_w/pixel_out presentation; source side may read concurrently (no interlock).

## Structure
- Shared package cursor_pkg: H_SIZE=32, V_SIZE=32, SPRITE_ADDR_W=10, state enum type (IDLE, CLEAR, WAIT_ROW, SHIFT); cursor sprite source imports the same size constants.
- Single module, no sub-modules: FSM, 5-bit row/col counters (concatenated as 10-bit counter for CLEAR), 32-bit shift register.

## Test plan
- Reset then idle: all outputs 0; row_valid=1 with no start -> row_ready stays 0, no writes.
- Clear: pulse clear -> exactly 1024 writes, addr 0..1023 ascending, pixel_out=0, done pulse at T+1025.
- Load: start, feed 32 rows row_data=32'h8000_0001 back-to-back -> per row col 0 and col 31 written 1, others 0; model of RAM matches; done once after row 31 col 31.
- Handshake stalls: deassert row_valid random 0-5 cycles between rows, row 5 = 32'hFFFF_0000 -> addresses {5,0..15}=1, {5,16..31}=0; no writes while waiting.
- Simultaneous start+clear in IDLE -> CLEAR sequence runs; start during CLEAR ignored; busy high throughout.
- Reset asserted mid-SHIFT (row 10, col 7) -> we=0, busy=0 immediately, no done; subsequent start loads full sprite correctly.

Source files
------------

// File: rtl/cursor_pkg.sv
// ============================================================================
// Module      : cursor_pkg
// Description : Shared cursor sprite geometry and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cursor_pkg;

    localparam int H_SIZE        = 32;
    localparam int V_SIZE        = 32;
    localparam int SPRITE_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_ROW = 2'd2,
        SHIFT    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cursor_sprite_loader.sv
// ============================================================================
// Module      : cursor_sprite_loader
// Description : Serialises 32-bit bitmap rows into single-pixel sprite RAM
//               writes and provides a zero-fill sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cursor_sprite_loader
    import cursor_pkg::*;
#(
    parameter int ADDR  = SPRITE_ADDR_W,
    parameter int ROW_W = H_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [ROW_W-1:0] row_data,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             we,
    output logic [ADDR-1:0]  addr_w,
    output logic             pixel_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_ST_IDLE     = IDLE;
    localparam logic [1:0] c_ST_CLEAR    = CLEAR;
    localparam logic [1:0] c_ST_WAIT_ROW = WAIT_ROW;
    localparam logic [1:0] c_ST_SHIFT    = SHIFT;

    localparam logic [4:0] c_LAST_COL = 5'(H_SIZE - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(V_SIZE - 1);

    logic [1:0]       r_state;
    logic [4:0]       r_row;
    logic [4:0]       r_col;
    logic [ROW_W-1:0] r_shift;

    logic [9:0] w_cnt;
    logic [9:0] w_cnt_nxt;
    logic [4:0] w_col_nxt;

    // Row and column counters double as one linear address during CLEAR.
    assign w_cnt     = {r_row, r_col};
    assign w_cnt_nxt = w_cnt + 10'd1;
    assign w_col_nxt = r_col + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_shift   <= '0;
            row_ready <= 1'b0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (clear) begin
                        r_state   <= c_ST_CLEAR;
                        r_row     <= '0;
                        r_col     <= '0;
                        we        <= 1'b1;
                        addr_w    <= '0;
                        pixel_out <= 1'b0;
                        busy      <= 1'b1;
                    end else if (start) begin
                        r_state   <= c_ST_WAIT_ROW;
                        r_row     <= '0;
                        row_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                c_ST_CLEAR: begin
                    if (w_cnt == 10'h3FF) begin
                        r_state <= c_ST_IDLE;
                        we      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        {r_row, r_col} <= w_cnt_nxt;
                        addr_w         <= w_cnt_nxt;
                    end
                end

                c_ST_WAIT_ROW: begin
                    // Column 0 is presented straight from the input word; the
                    // shift register then holds the next pixel in its MSB.
                    if (row_valid && row_ready) begin
                        r_state   <= c_ST_SHIFT;
                        row_ready <= 1'b0;
                        r_col     <= '0;
                        r_shift   <= {row_data[ROW_W-2:0], 1'b0};
                        we        <= 1'b1;
                        addr_w    <= {r_row, 5'd0};
                        pixel_out <= row_data[ROW_W-1];
                    end
                end

                c_ST_SHIFT: begin
                    if (r_col == c_LAST_COL) begin
                        we        <= 1'b0;
                        pixel_out <= 1'b0;
                        if (r_row == c_LAST_ROW) begin
                            r_state <= c_ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= c_ST_WAIT_ROW;
                            r_row     <= r_row + 5'd1;
                            row_ready <= 1'b1;
                        end
                    end else begin
                        r_col     <= w_col_nxt;
                        addr_w    <= {r_row, w_col_nxt};
                        pixel_out <= r_shift[ROW_W-1];
                        r_shift   <= {r_shift[ROW_W-2:0], 1'b0};
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cursor_sprite_loader.sv
// ============================================================================
// Module      : tb_cursor_sprite_loader
// Description : Self-checking bench for cursor_sprite_loader with a RAM image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cursor_sprite_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clear;
    logic [31:0] row_data;
    logic        row_valid;
    logic        row_ready;
    logic        we;
    logic [9:0]  addr_w;
    logic        pixel_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    logic        sim_ram [1024];
    int          wr_count = 0;
    logic [31:0] exp_rows [32];

    always #5 clk = ~clk;

    cursor_sprite_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .we        (we),
        .addr_w    (addr_w),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    // Sprite RAM image: commits each presented write on the next edge
    always @(posedge clk) begin
        if (we) begin
            sim_ram[addr_w] <= pixel_out;
            wr_count        <= wr_count + 1;
        end
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clear = 1'b0; row_valid = 1'b0; row_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({we, addr_w, pixel_out, row_ready, busy, done} !== 15'd0)
            $display("FAIL reset_hold: outputs %h expected 0", {we, addr_w, pixel_out, row_ready, busy, done});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({we, addr_w, pixel_out, row_ready, busy, done} !== 15'd0)
            $display("FAIL reset_release: outputs %h expected 0", {we, addr_w, pixel_out, row_ready, busy, done});
        else n_pass++;
    endtask

    task automatic test_idle_ignore();
        int bad  = 0;
        int base = wr_count;
        row_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            row_data = $urandom;
            @(negedge clk);
            if (row_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        row_valid = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL idle_ignore: %0d bad cycles, expected 0", bad);
        else n_pass++;
        n_checks++;
        if (wr_count - base !== 0) $display("FAIL idle_writes: got %0d writes expected 0", wr_count - base);
        else n_pass++;
    endtask

    // Clear sequence; with_start also asserts start with clear and during it
    task automatic test_clear(input bit with_start);
        int base  = wr_count;
        int b_we  = 0;
        int b_adr = 0;
        int b_pix = 0;
        int b_bsy = 0;
        int b_dn  = 0;
        int b_ram = 0;
        @(negedge clk);
        clear = 1'b1; start = with_start;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            if (we !== 1'b1) b_we++;
            if (addr_w !== 10'(k - 1)) b_adr++;
            if (pixel_out !== 1'b0) b_pix++;
            if (busy !== 1'b1) b_bsy++;
            if (done !== 1'b0) b_dn++;
            start = with_start && (k % 97 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (b_we !== 0) $display("FAIL clear_we: %0d cycles without write, expected 0", b_we);
        else n_pass++;
        n_checks++;
        if (b_adr !== 0) $display("FAIL clear_addr: %0d wrong addresses, expected 0", b_adr);
        else n_pass++;
        n_checks++;
        if (b_pix !== 0 || b_bsy !== 0 || b_dn !== 0)
            $display("FAIL clear_flags: pix %0d busy %0d done %0d bad cycles, expected 0", b_pix, b_bsy, b_dn);
        else n_pass++;
        n_checks++;
        if ({done, we, busy} !== 3'b100)
            $display("FAIL clear_done: done/we/busy %b expected 100", {done, we, busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, busy, row_ready} !== 3'b000)
            $display("FAIL clear_after: done/busy/row_ready %b expected 000", {done, busy, row_ready});
        else n_pass++;
        n_checks++;
        if (wr_count - base !== 1024) $display("FAIL clear_count: got %0d writes expected 1024", wr_count - base);
        else n_pass++;
        for (int a = 0; a < 1024; a++) if (sim_ram[a] !== 1'b0) b_ram++;
        n_checks++;
        if (b_ram !== 0) $display("FAIL clear_ram: %0d nonzero locations, expected 0", b_ram);
        else n_pass++;
    endtask

    // Loads exp_rows with random gaps; abort_row >= 0 resets at column 7 of that row
    task automatic load_sprite(input int max_gap, input int abort_row);
        int b_gap = 0;
        int b_wr  = 0;
        int b_end = 0;
        int b_ram = 0;
        int gap;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, row_ready} !== 2'b11) $display("FAIL load_start: busy/row_ready %b expected 11", {busy, row_ready});
        else n_pass++;
        for (int r = 0; r < 32; r++) begin
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) begin
                if (row_ready !== 1'b1 || we !== 1'b0 || busy !== 1'b1) b_gap++;
                row_data = $urandom;
                @(negedge clk);
            end
            if (row_ready !== 1'b1 || we !== 1'b0) b_gap++;
            row_valid = 1'b1;
            row_data  = exp_rows[r];
            @(negedge clk);
            for (int c = 0; c < 32; c++) begin
                row_valid = (c < 31) ? 1'($urandom % 2) : 1'b0;
                row_data  = $urandom;
                if (we !== 1'b1 || addr_w !== 10'(r * 32 + c) || pixel_out !== exp_rows[r][31 - c]
                    || row_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) b_wr++;
                if (r == abort_row && c == 7) begin
                    row_valid = 1'b0;
                    #2 reset = 1'b1;
                    #1;
                    n_checks++;
                    if ({we, busy, done, row_ready} !== 4'b0000)
                        $display("FAIL abort_outputs: we/busy/done/ready %b expected 0000", {we, busy, done, row_ready});
                    else n_pass++;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        if (done !== 1'b0 || we !== 1'b0) b_end++;
                    end
                    reset = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        if (done !== 1'b0 || busy !== 1'b0) b_end++;
                    end
                    for (int a = 0; a < r * 32 + 7; a++)
                        if (sim_ram[a] !== exp_rows[a / 32][31 - (a % 32)]) b_ram++;
                    n_checks++;
                    if (b_gap + b_wr + b_end !== 0)
                        $display("FAIL abort_seq: gap %0d write %0d end %0d bad cycles, expected 0", b_gap, b_wr, b_end);
                    else n_pass++;
                    n_checks++;
                    if (b_ram !== 0) $display("FAIL abort_partial: %0d wrong locations, expected 0", b_ram);
                    else n_pass++;
                    return;
                end
                @(negedge clk);
            end
            if (r < 31) begin
                if (we !== 1'b0 || row_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) b_end++;
            end else begin
                n_checks++;
                if ({we, done, busy, row_ready} !== 4'b0100)
                    $display("FAIL load_done: we/done/busy/ready %b expected 0100", {we, done, busy, row_ready});
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL load_done_pulse: done %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (b_gap !== 0) $display("FAIL load_wait: %0d bad wait cycles, expected 0", b_gap);
        else n_pass++;
        n_checks++;
        if (b_wr !== 0) $display("FAIL load_writes: %0d bad write cycles, expected 0", b_wr);
        else n_pass++;
        n_checks++;
        if (b_end !== 0) $display("FAIL load_row_end: %0d bad row boundaries, expected 0", b_end);
        else n_pass++;
        for (int a = 0; a < 1024; a++)
            if (sim_ram[a] !== exp_rows[a / 32][31 - (a % 32)]) b_ram++;
        n_checks++;
        if (b_ram !== 0) $display("FAIL load_ram: %0d wrong locations, expected 0", b_ram);
        else n_pass++;
    endtask

    task automatic test_load_pattern();
        for (int r = 0; r < 32; r++) exp_rows[r] = 32'h8000_0001;
        load_sprite(0, -1);
        n_checks++;
        if ({sim_ram[10'd0], sim_ram[10'd1], sim_ram[10'd31], sim_ram[10'd1023]} !== 4'b1011)
            $display("FAIL load_pattern_px: got %b expected 1011",
                     {sim_ram[10'd0], sim_ram[10'd1], sim_ram[10'd31], sim_ram[10'd1023]});
        else n_pass++;
    endtask

    task automatic test_stalls();
        int bad = 0;
        for (int r = 0; r < 32; r++) exp_rows[r] = $urandom;
        exp_rows[5] = 32'hFFFF_0000;
        load_sprite(5, -1);
        for (int c = 0; c < 32; c++)
            if (sim_ram[5 * 32 + c] !== ((c < 16) ? 1'b1 : 1'b0)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL stall_row5: %0d wrong pixels, expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 32; r++) exp_rows[r] = $urandom;
        load_sprite(2, 10);
        for (int r = 0; r < 32; r++) exp_rows[r] = $urandom;
        load_sprite(3, -1);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_clear(1'b0);
        test_load_pattern();
        test_stalls();
        test_clear(1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
